// File: rtl/din_debounce_pkg.sv
// Shared definitions for the din_debounce input-conditioning stage:
// FSM state encodings and default parameter values.
package din_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/din_debounce_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; clears to 0 on the
// asynchronous active-low clr.
module sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/din_debounce.sv
// Resynchronises and debounces a raw input level, producing a clean
// registered level, one-cycle rise/fall strobes and a busy flag.
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (DEBOUNCE < 2 || DEBOUNCE > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("din_debounce: DEBOUNCE out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync2 u_sync2 (
    .clk (clk),
    .clr (clr),
    .d   (din),
    .q   (s2)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // A reverting input is checked before completion, so a bounce on the
  // final qualifying edge is still rejected.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
